free_list_ctrl: RTL and testbench

FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

---
 rtl/rename_pkg.sv | 25 ++
 rtl/ckpt_table.sv | 33 +++
 rtl/free_list_ctrl.sv | 135 +++++++++++++
 tb/tb_free_list_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared constants, FSM encoding and lane popcount for the rename free-list controller.
package rename_pkg;

  localparam int WIDTH       = 4;
  localparam int N_REGS      = 64;
  localparam int N_INIT_FREE = 32;
  localparam int N_CKPT      = 4;
  localparam int PTR_W       = 6;
  localparam int CNT_W       = 7;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_REWIND = 1'b1
  } fl_state_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ckpt_table.sv
// Checkpoint storage for saved free-list front pointers: one write port, one async read port.
module ckpt_table
  import rename_pkg::*;
#(
  parameter int N_CKPT = rename_pkg::N_CKPT,
  parameter int TAG_W  = rename_pkg::PTR_W,
  parameter int ID_W   = $clog2(N_CKPT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [ID_W-1:0]  waddr,
  input  logic [TAG_W-1:0] wdata,
  input  logic [ID_W-1:0]  raddr,
  output logic [TAG_W-1:0] rdata
);

  logic [TAG_W-1:0] mem_r [N_CKPT];

  // Slot storage, cleared to pointer 0 on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CKPT; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list controller: grants rename groups against shadow front/back pointers,
// frees registers on commit, and rewinds the front pointer from checkpoints.
module free_list_ctrl
  import rename_pkg::*;
#(
  parameter int WIDTH       = rename_pkg::WIDTH,
  parameter int N_REGS      = rename_pkg::N_REGS,
  parameter int N_INIT_FREE = rename_pkg::N_INIT_FREE,
  parameter int N_CKPT      = rename_pkg::N_CKPT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      renValid,
  input  logic [WIDTH-1:0]          renMask,
  output logic                      renAccept,
  output logic                      renStall,
  input  logic                      comValid,
  input  logic [WIDTH-1:0]          comMask,
  input  logic                      ckptSave,
  input  logic [$clog2(N_CKPT)-1:0] ckptId,
  input  logic                      rewindReq,
  output logic [WIDTH-1:0]          take,
  output logic                      enableTake,
  output logic [WIDTH-1:0]          put,
  output logic                      enablePut,
  output logic                      rewind,
  output logic [5:0]                writeTag,
  output logic [6:0]                freeCount,
  output logic                      busy
);

  fl_state_e        state_r, state_nxt_s;
  logic [PTR_W-1:0] front_r, back_r, rw_tag_r;
  logic [CNT_W-1:0] cnt_r;

  logic [CNT_W-1:0] n_req_s, n_take_s, n_put_s, cnt_put_s, cnt_nxt_s;
  logic [PTR_W-1:0] front_take_s, front_nxt_s, back_nxt_s, diff_s, ckpt_rd_s;
  logic             grant_s, ckpt_we_s;

  ckpt_table #(
    .N_CKPT(N_CKPT),
    .TAG_W (PTR_W),
    .ID_W  ($clog2(N_CKPT))
  ) u_ckpt (
    .clk  (clk),
    .reset(reset),
    .we   (ckpt_we_s),
    .waddr(ckptId),
    .wdata(front_take_s),
    .raddr(ckptId),
    .rdata(ckpt_rd_s)
  );

  // Grant decision, pointer/count next-state and FSM transition
  always_comb begin
    n_req_s      = popcount(renMask);
    n_put_s      = '0;
    grant_s      = 1'b0;
    state_nxt_s  = ST_RUN;
    if (comValid) begin
      n_put_s = popcount(comMask);
    end else begin
      n_put_s = '0;
    end
    // A same-cycle put never counts toward the grant: compare against the registered count.
    if ((state_r == ST_RUN) && renValid && !rewindReq && (n_req_s <= cnt_r)) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    n_take_s     = grant_s ? n_req_s : {CNT_W{1'b0}};
    front_take_s = front_r + n_take_s[PTR_W-1:0];
    back_nxt_s   = back_r + n_put_s[PTR_W-1:0];
    diff_s       = back_nxt_s - rw_tag_r;
    cnt_put_s    = cnt_r + n_put_s;
    ckpt_we_s    = ckptSave && !rewindReq;

    // Equal pointers after a real rewind mean the list refilled completely.
    if (state_r == ST_REWIND) begin
      front_nxt_s = rw_tag_r;
      if (rw_tag_r == front_r) begin
        cnt_nxt_s = cnt_put_s;
      end else if (diff_s == {PTR_W{1'b0}}) begin
        cnt_nxt_s = CNT_W'(N_REGS);
      end else begin
        cnt_nxt_s = {1'b0, diff_s};
      end
    end else begin
      front_nxt_s = front_take_s;
      cnt_nxt_s   = cnt_r - n_take_s + n_put_s;
    end

    case (state_r)
      ST_RUN:    state_nxt_s = rewindReq ? ST_REWIND : ST_RUN;
      ST_REWIND: state_nxt_s = rewindReq ? ST_REWIND : ST_RUN;
      default:   state_nxt_s = ST_RUN;
    endcase
  end

  // State, pointers, count and latched rewind target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_RUN;
      front_r  <= '0;
      back_r   <= PTR_W'(N_INIT_FREE);
      cnt_r    <= CNT_W'(N_INIT_FREE);
      rw_tag_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      front_r <= front_nxt_s;
      back_r  <= back_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (rewindReq) begin
        rw_tag_r <= ckpt_rd_s;
      end else begin
        rw_tag_r <= rw_tag_r;
      end
    end
  end

  // Free-list handshake outputs; reset gating keeps them quiet while reset is low
  always_comb begin
    renAccept  = grant_s && reset;
    enableTake = grant_s && reset;
    take       = (grant_s && reset) ? renMask : {WIDTH{1'b0}};
    renStall   = renValid && !(grant_s && reset);
    enablePut  = comValid && reset;
    put        = (comValid && reset) ? comMask : {WIDTH{1'b0}};
    rewind     = (state_r == ST_REWIND);
    busy       = (state_r == ST_REWIND);
    writeTag   = (state_r == ST_REWIND) ? rw_tag_r : 6'd0;
    freeCount  = cnt_r;
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Self-checking bench for free_list_ctrl: directed scenarios then random traffic vs a pointer/count model.
module tb_free_list_ctrl;

  localparam int NR = 64;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       renValid = 1'b0, comValid = 1'b0, ckptSave = 1'b0, rewindReq = 1'b0;
  logic [3:0] renMask = 4'b0, comMask = 4'b0;
  logic [1:0] ckptId = 2'b0;
  logic       renAccept, renStall, enableTake, enablePut, rewind, busy;
  logic [3:0] take, put;
  logic [5:0] writeTag;
  logic [6:0] freeCount;

  int n_cmp = 0;
  int n_err = 0;

  int m_front, m_back, m_free, m_tag;
  int m_ckpt [NC];
  bit m_rw;

  free_list_ctrl dut (
    .clk(clk), .reset(reset),
    .renValid(renValid), .renMask(renMask), .renAccept(renAccept), .renStall(renStall),
    .comValid(comValid), .comMask(comMask),
    .ckptSave(ckptSave), .ckptId(ckptId), .rewindReq(rewindReq),
    .take(take), .enableTake(enableTake), .put(put), .enablePut(enablePut),
    .rewind(rewind), .writeTag(writeTag), .freeCount(freeCount), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_front = 0;
    m_back  = 32;
    m_free  = 32;
    m_tag   = 0;
    m_rw    = 1'b0;
    for (int i = 0; i < NC; i++) m_ckpt[i] = 0;
  endtask

  // One clock: drive at the falling edge, check 1 ns later, then advance the model.
  task automatic cyc(input bit rv, input logic [3:0] rm, input bit cv, input logic [3:0] cm,
                     input bit cs, input logic [1:0] cid, input bit rq);
    int  nreq, nt, np, back_after, d;
    bit  g;
    @(negedge clk);
    renValid = rv; renMask = rm; comValid = cv; comMask = cm;
    ckptSave = cs; ckptId = cid; rewindReq = rq;
    #1;
    nreq = $countones(rm);
    g    = !m_rw && rv && !rq && (nreq <= m_free);
    nt   = g ? nreq : 0;
    np   = cv ? $countones(cm) : 0;
    chk("freeCount", 32'(freeCount), 32'(m_free));
    chk("renAccept", 32'(renAccept), 32'(g));
    chk("renStall", 32'(renStall), 32'(rv && !g));
    chk("enableTake", 32'(enableTake), 32'(g));
    chk("take", 32'(take), g ? 32'(rm) : 32'd0);
    chk("enablePut", 32'(enablePut), 32'(cv));
    chk("put", 32'(put), cv ? 32'(cm) : 32'd0);
    chk("rewind", 32'(rewind), 32'(m_rw));
    chk("busy", 32'(busy), 32'(m_rw));
    chk("writeTag", 32'(writeTag), m_rw ? 32'(m_tag) : 32'd0);
    chk("rewind_take_excl", 32'(rewind && enableTake), 32'd0);
    if (cv) begin
      assert (m_free + np <= NR) else begin
        n_err++;
        $error("FAIL put_overflow: observed %0d expected at most %0d", m_free + np, NR);
      end
    end
    if (cs && !rq) m_ckpt[cid] = (m_front + nt) % 64;
    if (m_rw) begin
      back_after = (m_back + np) % 64;
      if (m_tag == m_front) m_free = m_free + np;
      else begin
        d = (back_after - m_tag + 64) % 64;
        m_free = (d == 0) ? 64 : d;
      end
      m_front = m_tag;
    end else begin
      m_front = (m_front + nt) % 64;
      m_free  = m_free - nt + np;
    end
    m_back = (m_back + np) % 64;
    if (rq) m_tag = m_ckpt[cid];
    m_rw = rq;
  endtask

  task automatic idle_inputs();
    renValid = 1'b0; renMask = 4'b0; comValid = 1'b0; comMask = 4'b0;
    ckptSave = 1'b0; ckptId = 2'b0; rewindReq = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    renValid = 1'b1; renMask = 4'b1111; comValid = 1'b1; comMask = 4'b1111;
    #1;
    chk("rst_renAccept", 32'(renAccept), 32'd0);
    chk("rst_enableTake", 32'(enableTake), 32'd0);
    chk("rst_take", 32'(take), 32'd0);
    chk("rst_enablePut", 32'(enablePut), 32'd0);
    chk("rst_put", 32'(put), 32'd0);
    chk("rst_rewind", 32'(rewind), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_writeTag", 32'(writeTag), 32'd0);
    chk("rst_freeCount", 32'(freeCount), 32'd32);
    idle_inputs();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] rm, cm;
    bit         cv;
    model_reset();
    do_reset();

    // Basic grant after reset
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    chk("s1_accept", 32'(renAccept), 32'd1);
    chk("s1_take", 32'(take), 32'hF);
    cyc(0, 4'b0, 0, 4'b0, 0, 2'd0, 0);
    chk("s1_count28", 32'(freeCount), 32'd28);

    // Stall at freeCount=3, a put does not unblock the same cycle
    for (int i = 0; i < 6; i++) cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    cyc(1, 4'b0001, 0, 4'b0, 0, 2'd0, 0);
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    chk("s2_count3", 32'(freeCount), 32'd3);
    chk("s2_stall", 32'(renStall), 32'd1);
    chk("s2_notake", 32'(enableTake), 32'd0);
    cyc(1, 4'b1111, 1, 4'b0011, 0, 2'd0, 0);
    chk("s2_stall_with_put", 32'(renStall), 32'd1);
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    chk("s2_count5", 32'(freeCount), 32'd5);
    chk("s2_granted", 32'(renAccept), 32'd1);

    // Checkpoint at front=8 and rewind to it
    do_reset();
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    cyc(1, 4'b1111, 0, 4'b0, 1, 2'd2, 0);
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd2, 1);
    chk("s3_rq_blocks_grant", 32'(renAccept), 32'd0);
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    chk("s3_rewind", 32'(rewind), 32'd1);
    chk("s3_tag8", 32'(writeTag), 32'd8);
    chk("s3_notake", 32'(enableTake), 32'd0);
    cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    chk("s3_run", 32'(busy), 32'd0);
    chk("s3_count24", 32'(freeCount), 32'd24);

    // Simultaneous take and put at freeCount=4
    for (int i = 0; i < 4; i++) cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    cyc(1, 4'b1111, 1, 4'b1111, 0, 2'd0, 0);
    chk("s4_count4", 32'(freeCount), 32'd4);
    chk("s4_grant", 32'(renAccept), 32'd1);
    cyc(0, 4'b0, 0, 4'b0, 0, 2'd0, 0);
    chk("s4_still4", 32'(freeCount), 32'd4);

    // Pointer wrap: front=62, back=2
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (i < 8) cyc(1, 4'b1111, 1, 4'b1111, 0, 2'd0, 0);
      else if (i == 8) cyc(1, 4'b1111, 1, 4'b0011, 0, 2'd0, 0);
      else cyc(1, 4'b1111, 0, 4'b0, 0, 2'd0, 0);
    end
    cyc(1, 4'b0011, 0, 4'b0, 0, 2'd0, 0);
    cyc(1, 4'b1111, 0, 4'b0, 1, 2'd3, 0);
    chk("s5_count4", 32'(freeCount), 32'd4);
    chk("s5_grant", 32'(renAccept), 32'd1);
    cyc(1, 4'b0001, 0, 4'b0, 0, 2'd0, 0);
    chk("s5_count0", 32'(freeCount), 32'd0);
    chk("s5_stall", 32'(renStall), 32'd1);
    cyc(1, 4'b0000, 0, 4'b0, 0, 2'd0, 0);
    chk("s5_zero_mask_grant", 32'(renAccept), 32'd1);
    cyc(0, 4'b0, 0, 4'b0, 0, 2'd3, 1);
    cyc(0, 4'b0, 0, 4'b0, 0, 2'd0, 0);
    chk("s5_wrapped_front", 32'(writeTag), 32'd2);

    // Reset in the middle of a rewind
    cyc(0, 4'b0, 0, 4'b0, 0, 2'd0, 1);
    @(posedge clk);
    #2;
    chk("s6_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("s6_rewind_dropped", 32'(rewind), 32'd0);
    chk("s6_busy_dropped", 32'(busy), 32'd0);
    chk("s6_writeTag", 32'(writeTag), 32'd0);
    chk("s6_count32", 32'(freeCount), 32'd32);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 4'b1111, 0, 4'b0, 1, 2'd1, 0);
    cyc(0, 4'b0, 0, 4'b0, 0, 2'd1, 1);
    cyc(0, 4'b0, 0, 4'b0, 0, 2'd0, 0);
    chk("s6_front_was0", 32'(writeTag), 32'd4);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rm = 4'($urandom);
      cm = 4'($urandom);
      cv = ($urandom % 2) == 0;
      if (m_free + $countones(cm) > NR) cv = 1'b0;
      cyc(($urandom % 4) != 0, rm, cv, cm, ($urandom % 4) == 0,
          2'($urandom), ($urandom % 16) == 0);
    end
    cyc(0, 4'b0, 0, 4'b0, 0, 2'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
